muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide execute unit; successor to the single-cycle ALU.
- Implements the LEGv8 MUL, SMULH, UMULH, SDIV and UDIV instructions.
- Sits in the execute stage beside the ALU and uses a valid/ready handshake on both input and output.
- Radix-2 shift-add/subtract, one bit per cycle; a destination tag travels with each operation for writeback.

---
 rtl/muldiv_unit_pkg.sv | 45 ++++
 rtl/muldiv_unit_md_datapath.sv | 75 +++++++
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - op codes, FSM states and LEGv8 decode for the multiply/divide unit
package muldiv_unit_pkg;

  typedef logic [2:0] md_op_t;

  localparam md_op_t MD_MUL   = 3'd0;
  localparam md_op_t MD_SMULH = 3'd1;
  localparam md_op_t MD_UMULH = 3'd2;
  localparam md_op_t MD_SDIV  = 3'd3;
  localparam md_op_t MD_UDIV  = 3'd4;

  typedef enum logic [1:0] {
    MD_IDLE   = 2'd0,
    MD_CALC   = 2'd1,
    MD_FINISH = 2'd2,
    MD_DONE   = 2'd3
  } md_state_e;

  localparam logic [10:0] LEG_OPC_MUL   = 11'b10011011000;
  localparam logic [10:0] LEG_OPC_SMULH = 11'b10011011010;
  localparam logic [10:0] LEG_OPC_UMULH = 11'b10011011110;
  localparam logic [10:0] LEG_OPC_DIV   = 11'b10011010110;
  localparam logic [5:0]  LEG_SHAMT_SDIV = 6'b000010;
  localparam logic [5:0]  LEG_SHAMT_UDIV = 6'b000011;

  // SDIV and UDIV share an opcode and are told apart by the shamt field.
  function automatic md_op_t md_decode(input logic [10:0] opcode, input logic [5:0] shamt);
    md_op_t op;
    op = MD_MUL;
    if (opcode == LEG_OPC_SMULH) op = MD_SMULH;
    else if (opcode == LEG_OPC_UMULH) op = MD_UMULH;
    else if (opcode == LEG_OPC_DIV && shamt == LEG_SHAMT_SDIV) op = MD_SDIV;
    else if (opcode == LEG_OPC_DIV && shamt == LEG_SHAMT_UDIV) op = MD_UDIV;
    return op;
  endfunction

  function automatic logic md_is_div(input md_op_t op);
    return (op == MD_SDIV) || (op == MD_UDIV);
  endfunction

  function automatic logic md_is_signed(input md_op_t op);
    return (op == MD_SMULH) || (op == MD_SDIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_md_datapath.sv
// rtl/muldiv_unit_md_datapath.sv - radix-2 shift-add multiply / restoring divide on unsigned magnitudes
module md_datapath
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             iterate,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   add_x, add_y, sum;
  logic             add_cin;

  always_comb begin
    acc_d = acc_q;
    lo_d  = lo_q;
    b_d   = b_q;
    // One shared adder: trial subtract of the divisor, or conditional add of the multiplicand.
    if (div_mode) begin
      add_x   = {acc_q, lo_q[WIDTH-1]};
      add_y   = ~{1'b0, b_q};
      add_cin = 1'b1;
    end else begin
      add_x   = {1'b0, acc_q};
      add_y   = lo_q[0] ? {1'b0, b_q} : '0;
      add_cin = 1'b0;
    end
    sum = add_x + add_y + {{WIDTH{1'b0}}, add_cin};

    if (load) begin
      acc_d = '0;
      lo_d  = a_mag;
      b_d   = b_mag;
    end else if (iterate) begin
      if (div_mode) begin
        if (!sum[WIDTH]) begin
          acc_d = sum[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = add_x[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = sum[WIDTH:1];
        lo_d  = {sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      lo_q  <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
    end
  end

  assign hi = acc_q;
  assign lo = lo_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MUL/SMULH/UMULH/SDIV/UDIV execute unit with valid/ready handshake
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dz,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  md_op_t           op_q, op_d;
  logic             neg_q, neg_d;
  logic             dz_q, dz_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_dz_q, out_dz_d;

  md_op_t           op_sel;
  logic             accept;
  logic             sel_signed;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] dp_hi, dp_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quot_fix, result;

  assign in_ready   = (state_q == MD_IDLE);
  assign busy       = (state_q != MD_IDLE);
  assign accept     = in_valid && in_ready && !flush;
  assign op_sel     = (in_op > MD_UDIV) ? MD_MUL : md_op_t'(in_op);
  assign sel_signed = md_is_signed(op_sel);
  assign a_mag      = (sel_signed && in_a[WIDTH-1]) ? -in_a : in_a;
  assign b_mag      = (sel_signed && in_b[WIDTH-1]) ? -in_b : in_b;

  md_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .iterate  (state_q == MD_CALC),
    .div_mode (md_is_div(op_q)),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .hi       (dp_hi),
    .lo       (dp_lo)
  );

  always_comb begin
    prod     = {dp_hi, dp_lo};
    prod_fix = neg_q ? -prod : prod;
    quot_fix = neg_q ? -dp_lo : dp_lo;
    case (op_q)
      MD_SMULH, MD_UMULH: result = prod_fix[2*WIDTH-1:WIDTH];
      MD_SDIV, MD_UDIV:   result = dz_q ? '0 : quot_fix;
      default:            result = prod_fix[WIDTH-1:0];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    op_d         = op_q;
    neg_d        = neg_q;
    dz_d         = dz_q;
    tag_d        = tag_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    out_dz_d     = out_dz_q;

    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          op_d    = op_sel;
          tag_d   = in_tag;
          neg_d   = sel_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
          count_d = '0;
          dz_d    = md_is_div(op_sel) && (in_b == '0);
          state_d = dz_d ? MD_FINISH : MD_CALC;
        end
      end
      MD_CALC: begin
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) state_d = MD_FINISH;
      end
      MD_FINISH: begin
        out_valid_d  = 1'b1;
        out_result_d = result;
        out_tag_d    = tag_q;
        out_dz_d     = dz_q;
        state_d      = MD_DONE;
      end
      default: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = MD_IDLE;
        end
      end
    endcase

    // A squash drops whatever was in flight, including a result about to be published.
    if (flush) begin
      state_d      = MD_IDLE;
      out_valid_d  = 1'b0;
      out_dz_d     = 1'b0;
      out_result_d = out_result_q;
      out_tag_d    = out_tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= MD_IDLE;
      count_q      <= '0;
      op_q         <= MD_MUL;
      neg_q        <= 1'b0;
      dz_q         <= 1'b0;
      tag_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_dz_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      op_q         <= op_d;
      neg_q        <= neg_d;
      dz_q         <= dz_d;
      tag_q        <= tag_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      out_dz_q     <= out_dz_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign out_dz     = out_dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

  localparam int W  = 64;
  localparam int TW = 5;
  localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ALL_ONE = {W{1'b1}};

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic          in_ready, out_valid, out_dz, busy;
  logic [2:0]    in_op;
  logic [W-1:0]  in_a, in_b, out_result;
  logic [TW-1:0] in_tag, out_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_dz     (out_dz),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0]        up;
    logic signed [2*W-1:0] sp;
    logic signed [W-1:0]   sq;
    up = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    case (op)
      3'd1: return sp[2*W-1:W];
      3'd2: return up[2*W-1:W];
      3'd3: begin
        if (b == '0) return '0;
        if (a == MIN_INT && b == ALL_ONE) return MIN_INT;
        sq = $signed(a) / $signed(b);
        return sq;
      end
      3'd4: return (b == '0) ? '0 : a / b;
      default: return up[W-1:0];
    endcase
  endfunction

  function automatic logic model_dz(input logic [2:0] op, input logic [W-1:0] b);
    return (op == 3'd3 || op == 3'd4) && (b == '0);
  endfunction

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag);
    @(negedge clk);
    chk("in_ready_before_accept", W'(in_ready), W'(1));
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = 3'($urandom);
    in_a     = {$urandom, $urandom};
    in_b     = {$urandom, $urandom};
    in_tag   = TW'($urandom);
    chk("busy_after_accept", W'(busy), W'(1));
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_after_take", W'(out_valid), W'(0));
    chk("in_ready_after_take", W'(in_ready), W'(1));
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [TW-1:0] tag,
                     input logic [W-1:0] exp_res, input logic exp_dz);
    int lat;
    issue(op, a, b, tag);
    wait_out(lat);
    chk({name, "_latency"}, W'(lat), exp_dz ? W'(1) : W'(W + 1));
    chk({name, "_result"}, out_result, exp_res);
    chk({name, "_tag"}, W'(out_tag), W'(tag));
    chk({name, "_dz"}, W'(out_dz), W'(exp_dz));
    chk({name, "_in_ready_done"}, W'(in_ready), W'(0));
    consume();
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int lat;
    logic [2:0]   op;
    logic [W-1:0] a, b;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_result", out_result, W'(0));
    chk("rst_out_tag", W'(out_tag), W'(0));
    chk("rst_out_dz", W'(out_dz), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    reset = 1'b0;

    run("udiv_15_10", 3'd4, W'(15), W'(10), 5'd7, W'(1), 1'b0);
    run("mul_15_10", 3'd0, W'(15), W'(10), 5'd1, W'(150), 1'b0);
    run("umulh_max", 3'd2, ALL_ONE, ALL_ONE, 5'd2, ALL_ONE - W'(1), 1'b0);
    run("smulh_m1_1", 3'd1, ALL_ONE, W'(1), 5'd3, ALL_ONE, 1'b0);
    run("sdiv_m15_4", 3'd3, -W'(15), W'(4), 5'd4, -W'(3), 1'b0);
    run("sdiv_min_m1", 3'd3, MIN_INT, ALL_ONE, 5'd5, MIN_INT, 1'b0);
    run("udiv_by_zero", 3'd4, W'(15), W'(0), 5'd6, W'(0), 1'b1);
    run("bad_op_is_mul", 3'd7, W'(6), W'(7), 5'd8, W'(42), 1'b0);

    // Backpressure: output held, new offer ignored until the edge after the take.
    issue(3'd4, W'(100), W'(7), 5'd3);
    wait_out(lat);
    chk("bp_result", out_result, W'(14));
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd0; in_a = W'(2); in_b = W'(3); in_tag = 5'd9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", W'(out_valid), W'(1));
      chk("bp_hold_result", out_result, W'(14));
      chk("bp_hold_tag", W'(out_tag), W'(3));
      chk("bp_hold_in_ready", W'(in_ready), W'(0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_take_valid", W'(out_valid), W'(0));
    chk("bp_no_same_edge_accept", W'(busy), W'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_accept_next_edge", W'(busy), W'(1));
    wait_out(lat);
    chk("bp_second_latency", W'(lat), W'(W + 1));
    chk("bp_second_result", out_result, W'(6));
    chk("bp_second_tag", W'(out_tag), W'(9));
    consume();

    // Flush mid-calculation at count 10.
    issue(3'd0, {$urandom, $urandom}, {$urandom, $urandom}, 5'd12);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_calc_busy", W'(busy), W'(0));
    chk("flush_calc_valid", W'(out_valid), W'(0));
    run("mul_after_flush", 3'd0, W'(3), W'(4), 5'd13, W'(12), 1'b0);

    // Flush in IDLE with an offer: no accept.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_a = W'(1); in_b = W'(1);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_no_accept", W'(busy), W'(0));

    // Flush in DONE beats out_ready and clears out_dz.
    issue(3'd3, W'(5), W'(0), 5'd14);
    wait_out(lat);
    chk("flush_done_pre_dz", W'(out_dz), W'(1));
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_done_valid", W'(out_valid), W'(0));
    chk("flush_done_dz", W'(out_dz), W'(0));
    chk("flush_done_in_ready", W'(in_ready), W'(1));

    // Reset while DONE and stalled.
    issue(3'd3, -W'(15), W'(4), 5'd21);
    wait_out(lat);
    chk("rst_done_pre_result", out_result, -W'(3));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_done_valid", W'(out_valid), W'(0));
    chk("rst_done_result", out_result, W'(0));
    chk("rst_done_tag", W'(out_tag), W'(0));
    chk("rst_done_dz", W'(out_dz), W'(0));
    chk("rst_done_busy", W'(busy), W'(0));
    chk("rst_done_in_ready", W'(in_ready), W'(1));
    run("mul_after_reset", 3'd0, W'(15), W'(1), 5'd2, W'(15), 1'b0);

    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0: b = '0;
        1: begin a = MIN_INT; b = ALL_ONE; end
        2: begin a = W'($signed(32'($urandom_range(0, 400)) - 32'sd200));
                 b = W'($signed(32'($urandom_range(1, 40)) - 32'sd20)); end
        3: b = W'($urandom_range(1, 1000));
        default: ;
      endcase
      run("rand", op, a, b, TW'(n), model(op, a, b), model_dz(op, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
